// File: rtl/cpu_pkg.sv
// Shared Toy-CPU definitions: opcodes, issue classes, decode FSM states and
// the combinational immediate/field helpers used by decode and execute.
package cpu_pkg;

   // Major opcodes (inst[6:0]) recognised by the decode stage
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_OP_V   = 7'b1010111;

   localparam logic [2:0] FUNCT3_BNE = 3'b001;

   // Instruction class handed to execute; encoding is shared with execute
   typedef enum logic [2:0] {
      CLS_NONE    = 3'd0,
      CLS_ALU_R   = 3'd1,
      CLS_ALU_I   = 3'd2,
      CLS_LOAD    = 3'd3,
      CLS_STORE   = 3'd4,
      CLS_LUI     = 3'd5,
      CLS_VEC     = 3'd6,
      CLS_ILLEGAL = 3'd7
   } issue_class_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DECODE    = 2'd1,
      ST_WAIT_OPND = 2'd2,
      ST_ISSUE     = 2'd3
   } dec_state_e;

   // bne is the only branch resolved in decode
   function automatic logic is_bne(input logic [31:0] w);
      return (w[6:0] == OPCODE_BRANCH) && (w[14:12] == FUNCT3_BNE);
   endfunction

   // Class of an instruction; bne never issues so it maps to NONE
   function automatic issue_class_e class_of(input logic [31:0] w);
      case (w[6:0])
         OPCODE_OP:     return CLS_ALU_R;
         OPCODE_OP_IMM: return CLS_ALU_I;
         OPCODE_LOAD:   return CLS_LOAD;
         OPCODE_STORE:  return CLS_STORE;
         OPCODE_LUI:    return CLS_LUI;
         OPCODE_OP_V:   return CLS_VEC;
         OPCODE_BRANCH: return is_bne(w) ? CLS_NONE : CLS_ILLEGAL;
         default:       return CLS_ILLEGAL;
      endcase
   endfunction

   // Source usage; illegal instructions neither stall nor mark anything busy
   function automatic logic uses_rs1(input issue_class_e c);
      return c inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_VEC};
   endfunction

   function automatic logic uses_rs2(input issue_class_e c);
      return c inside {CLS_ALU_R, CLS_STORE, CLS_VEC};
   endfunction

   function automatic logic writes_rd(input issue_class_e c);
      return c inside {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_LUI};
   endfunction

   // Sign-extended immediate selected by class (I, S or U format)
   function automatic logic [31:0] imm_gen(input issue_class_e c, input logic [31:0] w);
      case (c)
         CLS_ALU_I, CLS_LOAD: return {{20{w[31]}}, w[31:20]};
         CLS_STORE:           return {{20{w[31]}}, w[31:25], w[11:7]};
         CLS_LUI:             return {w[31:12], 12'b0};
         default:             return 32'b0;
      endcase
   endfunction

   // B-format branch displacement, sign-extended to 32 bits
   function automatic logic [31:0] b_imm(input logic [31:0] w);
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// Register busy scoreboard: one bit per architectural register, set when a
// writer issues and cleared on writeback. x0 is never marked busy.
module dec_scoreboard (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_en,
   input  logic [4:0] set_addr,
   input  logic       clr_en,
   input  logic [4:0] clr_addr,
   input  logic [4:0] q1_addr,
   input  logic [4:0] q2_addr,
   output logic       q1_busy,
   output logic       q2_busy
);

   logic [31:0] busy;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   // One-hot set/clear masks for this cycle's issue and writeback
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_addr != 5'd0)) set_mask[set_addr] = 1'b1;
      if (clr_en)                       clr_mask[clr_addr] = 1'b1;
   end

   // Busy vector update; applying the set after the clear makes set win on a collision
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the busy vector is state, not storage: it must reset, or stale bits would stall decode forever.
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~clr_mask) | set_mask;
   end

   // Queries read the registered vector, so a writeback is visible one cycle later
   assign q1_busy = busy[q1_addr];
   assign q2_busy = busy[q2_addr];

endmodule

// File: rtl/i_decode.sv
// Decode stage: holds one instruction from fetch, waits for its source
// operands, resolves bne locally and issues everything else to execute.
module i_decode
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inst_valid,
   input  logic [INST_WIDTH-1:0] inst,
   output logic                  inst_vacant,
   output logic                  offset_valid,
   output logic [ADDR_WIDTH-1:0] offset,
   output logic [4:0]            rf_raddr1,
   output logic [4:0]            rf_raddr2,
   input  logic [31:0]           rf_rdata1,
   input  logic [31:0]           rf_rdata2,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output logic [2:0]            issue_class,
   output logic [2:0]            issue_funct3,
   output logic [6:0]            issue_funct7,
   output logic [4:0]            issue_rd,
   output logic [31:0]           issue_rs1_val,
   output logic [31:0]           issue_rs2_val,
   output logic [31:0]           issue_imm,
   input  logic                  wb_valid,
   input  logic [4:0]            wb_rd
);

   dec_state_e             state;
   logic [INST_WIDTH-1:0]  inst_q;
   logic [31:0]            word;
   issue_class_e           cls;
   logic                   bne;
   logic                   need_rs1;
   logic                   need_rs2;
   logic                   busy1;
   logic                   busy2;
   logic                   opnd_ready;
   logic                   accept;
   logic                   set_en;
   logic signed [31:0]     br_off;

   // Field decode of the held instruction
   assign word      = inst_q[31:0];
   assign cls       = class_of(word);
   assign bne       = is_bne(word);
   assign rf_raddr1 = word[19:15];
   assign rf_raddr2 = word[24:20];
   assign need_rs1  = bne || uses_rs1(cls);
   assign need_rs2  = bne || uses_rs2(cls);
   assign opnd_ready = !(need_rs1 && busy1) && !(need_rs2 && busy2);

   // Taken-bne adjustment relative to fetch's already-incremented PC
   assign br_off = $signed(b_imm(word)) - 32'sd4;

   // Issue handshake; the destination becomes busy on that same edge
   assign accept = (state == ST_ISSUE) && issue_ready;
   assign set_en = accept && writes_rd(issue_class_e'(issue_class));

   dec_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (set_en),
      .set_addr (issue_rd),
      .clr_en   (wb_valid),
      .clr_addr (wb_rd),
      .q1_addr  (rf_raddr1),
      .q2_addr  (rf_raddr2),
      .q1_busy  (busy1),
      .q2_busy  (busy2)
   );

   // Decode FSM with registered handshake and issue outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         inst_q        <= '0;
         inst_vacant   <= 1'b1;
         offset_valid  <= 1'b0;
         offset        <= '0;
         issue_valid   <= 1'b0;
         issue_class   <= CLS_NONE;
         issue_funct3  <= '0;
         issue_funct7  <= '0;
         issue_rd      <= '0;
         issue_rs1_val <= '0;
         issue_rs2_val <= '0;
         issue_imm     <= '0;
      end else begin
         // NOTE: non-blocking assignments only, so every register samples pre-edge values.
         offset_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (inst_valid) begin
                  inst_q      <= inst;
                  inst_vacant <= 1'b0;
                  state       <= ST_DECODE;
               end
            end
            ST_DECODE, ST_WAIT_OPND: begin
               if (!opnd_ready) begin
                  state <= ST_WAIT_OPND;
               end else if (bne) begin
                  offset_valid <= 1'b1;
                  offset       <= (rf_rdata1 != rf_rdata2) ? ADDR_WIDTH'(br_off) : '0;
                  inst_vacant  <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  issue_valid   <= 1'b1;
                  issue_class   <= cls;
                  issue_funct3  <= word[14:12];
                  issue_funct7  <= word[31:25];
                  issue_rd      <= word[11:7];
                  issue_rs1_val <= rf_rdata1;
                  issue_rs2_val <= rf_rdata2;
                  issue_imm     <= imm_gen(cls, word);
                  state         <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_ready) begin
                  issue_valid <= 1'b0;
                  inst_vacant <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i_decode.sv
// Self-checking bench for i_decode: directed instructions with hand-computed
// expectations queued at stimulus time and compared by a separate monitor.
module tb_i_decode;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_valid = 1'b0;
   logic [31:0] inst = '0;
   logic        inst_vacant;
   logic        offset_valid;
   logic [31:0] offset;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        issue_valid;
   logic        issue_ready = 1'b1;
   logic [2:0]  issue_class;
   logic [2:0]  issue_funct3;
   logic [6:0]  issue_funct7;
   logic [4:0]  issue_rd;
   logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;

   logic [31:0] rf [32];
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   i_decode #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_valid(inst_valid), .inst(inst), .inst_vacant(inst_vacant),
      .offset_valid(offset_valid), .offset(offset),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_class(issue_class), .issue_funct3(issue_funct3),
      .issue_funct7(issue_funct7), .issue_rd(issue_rd),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_imm(issue_imm), .wb_valid(wb_valid), .wb_rd(wb_rd)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_off;
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [31:0] rs1v;
      logic [31:0] rs2v;
      logic [31:0] imm;
      logic [31:0] off;
   } exp_t;

   typedef struct {
      logic [31:0] w;
      logic [2:0]  cls;
      logic [31:0] imm;
   } vec_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   logic prev_off = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: pops one expectation per offset pulse or accepted issue
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_off <= 1'b0;
      end else begin
         if (offset_valid) begin
            check("offset_pulse_width", {31'b0, prev_off}, 32'd0);
            if (exp_q.size() == 0) begin
               check("offset_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("offset_kind", {31'b0, mon_e.is_off}, 32'd1);
               check("offset_value", offset, mon_e.off);
            end
         end
         if (issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
               check("issue_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("issue_kind",   {31'b0, mon_e.is_off}, 32'd0);
               check("issue_class",  {29'b0, issue_class},  {29'b0, mon_e.cls});
               check("issue_funct3", {29'b0, issue_funct3}, {29'b0, mon_e.f3});
               check("issue_funct7", {25'b0, issue_funct7}, {25'b0, mon_e.f7});
               check("issue_rd",     {27'b0, issue_rd},     {27'b0, mon_e.rd});
               check("issue_imm",    issue_imm,             mon_e.imm);
               if (mon_e.cls inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6})
                  check("issue_rs1_val", issue_rs1_val, mon_e.rs1v);
               if (mon_e.cls inside {3'd1, 3'd4, 3'd6})
                  check("issue_rs2_val", issue_rs2_val, mon_e.rs2v);
            end
         end
         prev_off <= offset_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      int c;
      c = 0;
      while (!inst_vacant && c < 40) begin
         tick();
         c++;
      end
      check("vacant_before_send", {31'b0, inst_vacant}, 32'd1);
      inst_valid = 1'b1;
      inst       = w;
      tick();
      inst_valid = 1'b0;
      inst       = '0;
   endtask

   task automatic push_issue(input logic [31:0] w, input logic [2:0] cls,
                             input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      e.is_off = 1'b0; e.cls = cls; e.f3 = w[14:12]; e.f7 = w[31:25]; e.rd = w[11:7];
      e.rs1v = r1; e.rs2v = r2; e.imm = imm; e.off = '0;
      exp_q.push_back(e);
   endtask

   task automatic push_off(input logic [31:0] off);
      exp_t e;
      e.is_off = 1'b1; e.cls = '0; e.f3 = '0; e.f7 = '0; e.rd = '0;
      e.rs1v = '0; e.rs2v = '0; e.imm = '0; e.off = off;
      exp_q.push_back(e);
   endtask

   // Register file is written on the edge that clears the busy bit
   task automatic writeback(input logic [4:0] rd, input logic [31:0] val);
      wb_valid = 1'b1;
      wb_rd    = rd;
      tick();
      wb_valid = 1'b0;
      rf[rd]   = val;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_inst_vacant"},  {31'b0, inst_vacant},  32'd1);
      check({tag, "_offset_valid"}, {31'b0, offset_valid}, 32'd0);
      check({tag, "_offset"},       offset,                32'd0);
      check({tag, "_issue_valid"},  {31'b0, issue_valid},  32'd0);
      check({tag, "_issue_class"},  {29'b0, issue_class},  32'd0);
      check({tag, "_issue_rd"},     {27'b0, issue_rd},     32'd0);
      check({tag, "_issue_imm"},    issue_imm,             32'd0);
      check({tag, "_issue_rs1"},    issue_rs1_val,         32'd0);
   endtask

   vec_t table_v[5] = '{
      '{32'h123453B7, 3'd5, 32'h12345000},   // lui x7,0x12345
      '{32'hFFC0A403, 3'd3, 32'hFFFFFFFC},   // lw x8,-4(x1)
      '{32'h02208057, 3'd6, 32'h00000000},   // OP-V, rs1=x1 rs2=x2
      '{32'h0000007F, 3'd7, 32'h00000000},   // unknown opcode
      '{32'h00208463, 3'd7, 32'h00000000}    // beq: non-bne branch
   };

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[1] = 32'd3;
      rf[2] = 32'd5;

      // Reset values
      #12;
      check_reset_values("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      // addi x5,x0,7: issue one cycle after capture, vacant after handshake
      push_issue(32'h00700293, 3'd2, 32'd7, 32'd0, 32'd0);
      send(32'h00700293);
      check("addi_latency_e0", {31'b0, issue_valid}, 32'd0);
      tick();
      check("addi_latency_e1", {31'b0, issue_valid}, 32'd1);
      check("addi_vacant_low", {31'b0, inst_vacant}, 32'd0);
      tick();
      check("addi_vacant_back", {31'b0, inst_vacant}, 32'd1);
      check("addi_valid_drop",  {31'b0, issue_valid}, 32'd0);

      // add x6,x5,x0 stalls on busy x5 until the cycle after writeback
      push_issue(32'h00028333, 3'd1, 32'd0, 32'd42, 32'd0);
      send(32'h00028333);
      for (int i = 0; i < 4; i++) begin
         check("raw_stall", {31'b0, issue_valid}, 32'd0);
         tick();
      end
      writeback(5'd5, 32'd42);
      check("raw_no_bypass", {31'b0, issue_valid}, 32'd0);
      tick();
      check("raw_release", {31'b0, issue_valid}, 32'd1);
      tick();
      writeback(5'd6, 32'd1);

      // bne x1,x2,+8 taken (3 vs 5): offset 4, vacant with the pulse
      push_off(32'd4);
      send(32'h00209463);
      tick();
      check("bne_pulse",  {31'b0, offset_valid}, 32'd1);
      check("bne_vacant", {31'b0, inst_vacant},  32'd1);
      tick();
      check("bne_pulse_end", {31'b0, offset_valid}, 32'd0);

      // bne not taken (5 vs 5): offset 0
      rf[1] = 32'd5;
      push_off(32'd0);
      send(32'h00209463);
      tick(2);

      // bne x1,x2,-4 taken: offset -8
      rf[1] = 32'd3;
      push_off(32'hFFFFFFF8);
      send(32'hFE209EE3);
      tick(2);

      // addi x1,x0,9 makes x1 busy; bne waits for its writeback
      push_issue(32'h00900093, 3'd2, 32'd9, 32'd0, 32'd0);
      send(32'h00900093);
      tick(2);
      push_off(32'd0);
      send(32'h00209463);
      for (int i = 0; i < 3; i++) begin
         check("bne_stall", {31'b0, offset_valid}, 32'd0);
         tick();
      end
      writeback(5'd1, 32'd5);
      check("bne_no_bypass", {31'b0, offset_valid}, 32'd0);
      tick();
      check("bne_release", {31'b0, offset_valid}, 32'd1);
      tick();

      // sw x2,12(x1) under backpressure: outputs hold, operands stay registered
      issue_ready = 1'b0;
      push_issue(32'h0020A623, 3'd4, 32'd12, 32'd5, 32'd5);
      send(32'h0020A623);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",  {31'b0, issue_valid}, 32'd1);
         check("bp_vacant", {31'b0, inst_vacant}, 32'd0);
         check("bp_class",  {29'b0, issue_class}, 32'd4);
         check("bp_imm",    issue_imm,            32'd12);
         check("bp_rs1",    issue_rs1_val,        32'd5);
         if (i == 1) rf[1] = 32'd99;
         tick();
      end
      issue_ready = 1'b1;
      tick();
      check("bp_vacant_back", {31'b0, inst_vacant}, 32'd1);
      check("bp_valid_drop",  {31'b0, issue_valid}, 32'd0);
      rf[1] = 32'd5;

      // Writeback of x5 on the same edge another x5 writer issues: stays busy
      issue_ready = 1'b0;
      push_issue(32'h00100293, 3'd2, 32'd1, 32'd0, 32'd0);
      send(32'h00100293);
      tick();
      issue_ready = 1'b1;
      wb_valid    = 1'b1;
      wb_rd       = 5'd5;
      tick();
      wb_valid = 1'b0;
      rf[5]    = 32'd77;
      push_issue(32'h00028333, 3'd1, 32'd0, 32'd11, 32'd0);
      send(32'h00028333);
      for (int i = 0; i < 3; i++) begin
         check("set_wins_stall", {31'b0, issue_valid}, 32'd0);
         tick();
      end
      writeback(5'd5, 32'd11);
      tick();
      check("set_wins_release", {31'b0, issue_valid}, 32'd1);
      tick();
      writeback(5'd6, 32'd2);

      // Remaining classes: LUI, LOAD, VEC and ILLEGAL encodings
      foreach (table_v[k]) begin
         push_issue(table_v[k].w, table_v[k].cls, table_v[k].imm,
                    rf[table_v[k].w[19:15]], rf[table_v[k].w[24:20]]);
         send(table_v[k].w);
         tick(2);
      end

      // Reset mid-ISSUE with x3 busy: outputs return to reset values, scoreboard clears
      push_issue(32'h00100193, 3'd2, 32'd1, 32'd0, 32'd0);
      send(32'h00100193);
      tick(2);
      issue_ready = 1'b0;
      send(32'h00700293);
      tick();
      check("pre_reset_issue", {31'b0, issue_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      issue_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      rf[3] = 32'd21;
      push_issue(32'h00018233, 3'd1, 32'd0, 32'd21, 32'd0);
      send(32'h00018233);
      tick();
      check("reset_clears_scoreboard", {31'b0, issue_valid}, 32'd1);
      tick(3);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i_decode.md
# i_decode

Decode stage of the Toy-CPU front end, directly downstream of `i_fetch`. It accepts one instruction per `inst_valid`/`inst_vacant` handshake and decodes RV32I plus the OP-V class. It resolves `bne` locally, returning the PC adjustment on `offset_valid`/`offset`. All other instructions are issued with register operands and a sign-extended immediate to the execute stage over a valid/ready handshake. A 32-entry busy scoreboard stalls issue and branch resolution until source operands have been written back.

## Interface
- `ADDR_WIDTH`, 32: PC/offset width.
- `INST_WIDTH`, 32: instruction width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  fetch presents `inst` (one-cycle pulse).
- `inst`  in  INST_WIDTH  instruction word.
- `inst_vacant`  out  1  decode can accept an instruction (registered).
- `offset_valid`  out  1  one-cycle pulse, `offset` valid for the resolved `bne`.
- `offset`  out  ADDR_WIDTH  signed PC adjustment relative to fetch's already-incremented PC.
- `rf_raddr1`, `rf_raddr2`  out  5  register-file read addresses (= rs1, rs2 of held instruction).
- `rf_rdata1`, `rf_rdata2`  in  32  combinational register-file read data.
- `issue_valid`  out  1  decoded instruction presented to execute.
- `issue_ready`  in  1  execute accepts.
- `issue_class`  out  3  NONE/ALU_R/ALU_I/LOAD/STORE/LUI/VEC/ILLEGAL.
- `issue_funct3`  out  3; `issue_funct7`  out  7; `issue_rd`  out  5.
- `issue_rs1_val`, `issue_rs2_val`  out  32  operand values.
- `issue_imm`  out  32  sign-extended immediate (I/S/U per class; 0 for R/VEC).
- `wb_valid`  in  1; `wb_rd`  in  5  writeback completion, clears busy bit.

## Operation
- States: IDLE, DECODE, WAIT_OPND, ISSUE.
- IDLE: `inst_vacant`=1. On `inst_valid`, latch `inst`, `inst_vacant`<=0, go to DECODE.
- DECODE/WAIT_OPND: operands ready = neither used source is busy in the registered scoreboard. x0 is never busy. Unused sources are ignored: LUI uses none; ALU_I and LOAD use rs1 only.
  - If not ready: WAIT_OPND, re-evaluated every cycle.
  - If ready and `bne`: `offset_valid`<=1. `offset` <= (rs1_val != rs2_val) ? B-imm − 4 : 0, computed in ADDR_WIDTH two's complement. Next state IDLE with `inst_vacant`<=1.
  - If ready and other: register all `issue_*` fields, `issue_valid`<=1, go to ISSUE.
- Other BRANCH funct3 values, and unknown opcodes, issue as ILLEGAL with no scoreboard effect.
- ISSUE: hold every `issue_*` output stable while `issue_ready`=0. On `issue_valid && issue_ready`:
  - `issue_valid`<=0, `inst_vacant`<=1, go to IDLE.
  - Set the busy bit for rd if the class writes rd (ALU_R, ALU_I, LOAD, LUI) and rd≠0.
- Scoreboard: `wb_valid` clears bit `wb_rd`. If set and clear hit the same register in one cycle, set wins. A clear takes effect next cycle, so there is no same-cycle bypass; the register file is written on that same edge.
- `inst_valid` while not in IDLE is ignored; fetch guarantees this does not occur.

## Timing
- Reset values: `inst_vacant`=1, `offset_valid`=0, `offset`=0, `issue_valid`=0, all `issue_*`=0, scoreboard all clear, state IDLE.
- Reset mid-operation discards the held instruction and clears the scoreboard immediately (asynchronous).
- Latency, no hazard: capture edge E0; `issue_valid` or `offset_valid` high after E1; `inst_vacant` high again one edge after the issue handshake, or after E1 for `bne`.
- Hazard: decision occurs on the edge after the clearing `wb_valid` edge.
- `offset_valid` is high for exactly one cycle per `bne`.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, OP_V);
  - `FUNCT3_BNE`;
  - `issue_class` enum/localparams, shared with execute.
- Sub-module `dec_scoreboard`: 32-bit busy vector with set port, clear port, and two combinational query ports. The set-wins rule is implemented there.
- Immediate generation is a combinational function in the package.

## Test plan
- Reset: assert `rst_n`=0 mid-ISSUE -> all outputs at reset values, `inst_vacant`=1, scoreboard clear.
- `addi x5,x0,7` (0x00700293) -> `issue_valid` one cycle after capture, class ALU_I, rd=5, imm=7. After handshake, busy[5]=1; `wb_valid`,`wb_rd`=5 clears it.
- `bne x1,x2,+8` (0x00209463), x1=3, x2=5 -> `offset_valid` pulse, `offset`=4. With x1=x2=5 -> `offset`=0. With B-imm −4 and taken -> `offset`=0xFFFFFFF8.
- `bne` with x1 busy -> no `offset_valid` until the cycle after `wb_valid`,`wb_rd`=1. Then it resolves with updated `rf_rdata1`.
- Backpressure: `issue_ready`=0 for 5 cycles -> `issue_*` stable, `inst_vacant`=0. Accept on cycle 6 -> `inst_vacant`=1 the next cycle.
- Same-cycle `wb_valid` for rd=5 while issuing another writer of x5 -> busy[5] remains 1.
